// File: rtl/uart_dec_reader.sv
// Decimal keystroke reader: buffers digits, echoes accepted keys, converts on <Enter>.
// Define UART_DEC_READER_BACKSPACE_EN to enable backspace (0x08/0x7F) editing.
module uart_dec_reader #(
    parameter int MAX_DIGITS = 5,
    parameter int WIDTH      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rx_valid,
    input  logic [7:0]       rx_byte,
    input  logic             echo_ready,
    output logic             echo_valid,
    output logic [7:0]       echo_byte,
    output logic             busy,
    output logic [2:0]       digit_cnt,
    output logic             num_valid,
    output logic [WIDTH-1:0] num_value,
    output logic             num_ovf
);
    localparam int               ACC_W   = WIDTH + 4;
    localparam logic [ACC_W-1:0] ACC_MAX = {4'b0000, {WIDTH{1'b1}}};
    localparam logic [2:0]       MAX_CNT = 3'(MAX_DIGITS);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_ECHO    = 3'd2,
        ST_CONVERT = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    state_e           state_q;
    state_e           ret_q;
    logic [2:0]       cnt_q;
    logic [2:0]       idx_q;
    logic [3:0]       dig_q [MAX_DIGITS];
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic             echo_valid_q;
    logic [7:0]       echo_byte_q;
    logic             busy_q;
    logic             num_valid_q;
    logic [WIDTH-1:0] num_value_q;
    logic             num_ovf_q;
`ifdef UART_DEC_READER_BACKSPACE_EN
    logic [1:0]       bs_step_q;
`endif

    logic [2:0]       idx_rd_s;
    logic [ACC_W-1:0] acc_mul_s;
    logic [ACC_W-1:0] acc_next_s;
    logic             ovf_step_s;
    logic             is_digit_s;

    // One conversion step: acc*10 + digit, saturated to the result range.
    always_comb begin
        idx_rd_s   = (idx_q < MAX_CNT) ? idx_q : 3'd0;
        acc_mul_s  = acc_q * ACC_W'(4'd10) + ACC_W'(dig_q[idx_rd_s]);
        is_digit_s = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
        if (acc_mul_s > ACC_MAX) begin
            acc_next_s = ACC_MAX;
            ovf_step_s = 1'b1;
        end else begin
            acc_next_s = acc_mul_s;
            ovf_step_s = 1'b0;
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ret_q        <= ST_IDLE;
            cnt_q        <= 3'd0;
            idx_q        <= 3'd0;
            acc_q        <= {ACC_W{1'b0}};
            ovf_q        <= 1'b0;
            echo_valid_q <= 1'b0;
            echo_byte_q  <= 8'h00;
            busy_q       <= 1'b0;
            num_valid_q  <= 1'b0;
            num_value_q  <= {WIDTH{1'b0}};
            num_ovf_q    <= 1'b0;
            for (int i = 0; i < MAX_DIGITS; i++) dig_q[i] <= 4'd0;
`ifdef UART_DEC_READER_BACKSPACE_EN
            bs_step_q    <= 2'd0;
`endif
        end else begin
            num_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_COLLECT;
                        busy_q      <= 1'b1;
                        cnt_q       <= 3'd0;
                        num_value_q <= {WIDTH{1'b0}};
                        num_ovf_q   <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (rx_valid) begin
                        if (is_digit_s) begin
                            if (cnt_q < MAX_CNT) begin
                                dig_q[cnt_q] <= rx_byte[3:0];
                                cnt_q        <= cnt_q + 3'd1;
                                echo_byte_q  <= rx_byte;
                                echo_valid_q <= 1'b1;
                                ret_q        <= ST_COLLECT;
                                state_q      <= ST_ECHO;
                            end
                        end else if (rx_byte == 8'h0D) begin
                            echo_byte_q  <= 8'h0D;
                            echo_valid_q <= 1'b1;
                            ret_q        <= ST_CONVERT;
                            state_q      <= ST_ECHO;
                        end
`ifdef UART_DEC_READER_BACKSPACE_EN
                        else if (((rx_byte == 8'h08) || (rx_byte == 8'h7F)) && (cnt_q != 3'd0)) begin
                            cnt_q        <= cnt_q - 3'd1;
                            echo_byte_q  <= 8'h08;
                            echo_valid_q <= 1'b1;
                            bs_step_q    <= 2'd1;
                            ret_q        <= ST_COLLECT;
                            state_q      <= ST_ECHO;
                        end
`endif
                    end
                end
                ST_ECHO: begin
                    if (echo_ready) begin
`ifdef UART_DEC_READER_BACKSPACE_EN
                        // Erase sequence: backspace, space, backspace.
                        if (bs_step_q == 2'd1) begin
                            echo_byte_q <= 8'h20;
                            bs_step_q   <= 2'd2;
                        end else if (bs_step_q == 2'd2) begin
                            echo_byte_q <= 8'h08;
                            bs_step_q   <= 2'd0;
                        end else
`endif
                        begin
                            echo_valid_q <= 1'b0;
                            state_q      <= ret_q;
                            acc_q        <= {ACC_W{1'b0}};
                            idx_q        <= 3'd0;
                            ovf_q        <= 1'b0;
                        end
                    end
                end
                ST_CONVERT: begin
                    if (idx_q == cnt_q) begin
                        state_q     <= ST_DONE;
                        num_valid_q <= 1'b1;
                        num_value_q <= acc_q[WIDTH-1:0];
                        num_ovf_q   <= ovf_q;
                    end else begin
                        acc_q <= acc_next_s;
                        ovf_q <= ovf_q | ovf_step_s;
                        idx_q <= idx_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    busy_q       <= 1'b0;
                    echo_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign echo_valid = echo_valid_q;
    assign echo_byte  = echo_byte_q;
    assign busy       = busy_q;
    assign digit_cnt  = cnt_q;
    assign num_valid  = num_valid_q;
    assign num_value  = num_value_q;
    assign num_ovf    = num_ovf_q;

endmodule

// File: tb/tb_uart_dec_reader.sv
// Scoreboard bench for uart_dec_reader: a keystroke driver feeds a digit-string
// reference model; a negedge monitor checks echoes, results and latency.
`timescale 1ns/1ps
module tb_uart_dec_reader;
    localparam int MAXD = 5;
    localparam int W    = 16;

    typedef struct {
        longint val;
        bit     ovf;
        int     nd;
    } num_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         rx_valid;
    logic [7:0]   rx_byte;
    logic         echo_ready;
    logic         echo_valid;
    logic [7:0]   echo_byte;
    logic         busy;
    logic [2:0]   digit_cnt;
    logic         num_valid;
    logic [W-1:0] num_value;
    logic         num_ovf;

    uart_dec_reader #(.MAX_DIGITS(MAXD), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .echo_ready(echo_ready), .echo_valid(echo_valid), .echo_byte(echo_byte),
        .busy(busy), .digit_cnt(digit_cnt), .num_valid(num_valid),
        .num_value(num_value), .num_ovf(num_ovf)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         xfer_cnt = 0;
    int         num_seen = 0;
    int         enter_cyc = 0;
    bit         ready_low = 1'b0;
    bit         prev_pend = 1'b0;
    bit         prev_num = 1'b0;
    logic [7:0] prev_byte;
    logic [7:0] mon_byte;
    num_t       mon_num;
    logic [7:0] echo_q[$];
    num_t       num_q[$];
    int         digits[$];

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        echo_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            echo_ready = ready_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an echo transfer or a result.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pend = 1'b0;
                prev_num  = 1'b0;
            end else begin
                if (prev_pend) begin
                    chk("echo_hold_valid", echo_valid, 1);
                    chk("echo_hold_byte", echo_byte, prev_byte);
                end
                if (echo_valid && echo_ready) begin
                    xfer_cnt++;
                    chk("echo_expected", echo_q.size() > 0, 1);
                    if (echo_q.size() > 0) begin
                        mon_byte = echo_q.pop_front();
                        chk("echo_byte", echo_byte, mon_byte);
                    end
                    if (echo_byte == 8'h0D) enter_cyc = cyc;
                end
                prev_pend = echo_valid && !echo_ready;
                prev_byte = echo_byte;
                if (prev_num) chk("num_valid_pulse", num_valid, 0);
                if (num_valid) begin
                    num_seen++;
                    chk("num_expected", num_q.size() > 0, 1);
                    if (num_q.size() > 0) begin
                        mon_num = num_q.pop_front();
                        chk("num_value", num_value, mon_num.val);
                        chk("num_ovf", num_ovf, mon_num.ovf);
                        chk("num_latency", cyc - enter_cyc, mon_num.nd + 2);
                    end
                end
                prev_num = num_valid;
            end
        end
    end

    task automatic wait_xfer(input int tgt);
        for (int k = 0; k < 300 && xfer_cnt < tgt; k++) tick();
        chk("echo_timeout", xfer_cnt >= tgt, 1);
    endtask

    task automatic wait_num(input int tgt);
        for (int k = 0; k < 60 && num_seen < tgt; k++) tick();
        chk("num_timeout", num_seen >= tgt, 1);
        chk("idle_busy", busy, 0);
        chk("idle_digit_cnt", digit_cnt, digits.size());
    endtask

    task automatic pulse_raw(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        digits.delete();
        chk("start_busy", busy, 1);
        chk("start_cnt", digit_cnt, 0);
        chk("start_value", num_value, 0);
        chk("start_ovf", num_ovf, 0);
    endtask

    // Reference model: digits accumulate as a string; the value is its plain decimal meaning.
    task automatic send_key(input logic [7:0] b);
        int     n_echo;
        int     tgt;
        int     tgt_num;
        longint v;
        num_t   e;
        n_echo  = 0;
        tgt_num = num_seen + 1;
        if (b >= 8'h30 && b <= 8'h39) begin
            if (digits.size() < MAXD) begin
                digits.push_back(int'(b) - 48);
                echo_q.push_back(b);
                n_echo = 1;
            end
        end else if (b == 8'h0D) begin
            v = 0;
            foreach (digits[i]) v = v * 10 + digits[i];
            e.val = (v > 65535) ? 65535 : v;
            e.ovf = (v > 65535);
            e.nd  = digits.size();
            num_q.push_back(e);
            echo_q.push_back(b);
            n_echo = 1;
        end
`ifdef UART_DEC_READER_BACKSPACE_EN
        else if ((b == 8'h08 || b == 8'h7F) && digits.size() > 0) begin
            void'(digits.pop_back());
            echo_q.push_back(8'h08);
            echo_q.push_back(8'h20);
            echo_q.push_back(8'h08);
            n_echo = 3;
        end
`endif
        tgt = xfer_cnt + n_echo;
        pulse_raw(b);
        if (n_echo == 0) chk("drop_no_echo", echo_valid, 0);
        else wait_xfer(tgt);
        if (b == 8'h0D) wait_num(tgt_num);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_key(s[i]);
    endtask

    task automatic check_reset_outputs();
        chk("rst_echo_valid", echo_valid, 0);
        chk("rst_echo_byte", echo_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_digit_cnt", digit_cnt, 0);
        chk("rst_num_valid", num_valid, 0);
        chk("rst_num_value", num_value, 0);
        chk("rst_num_ovf", num_ovf, 0);
    endtask

    function automatic logic [7:0] rand_key();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return 8'(8'h30 + $urandom_range(0, 9));
        else if (r == 7) return 8'(8'h61 + $urandom_range(0, 25));
        else if (r == 8) return ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h7F;
        else             return 8'h20;
    endfunction

    initial begin
        int tgt;
        int n;
        rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        #2 rst = 1'b1;
        #2 check_reset_outputs();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        pulse_raw(8'h35);
        chk("idle_rx_ignored_cnt", digit_cnt, 0);
        chk("idle_rx_ignored_echo", echo_valid, 0);

        do_start(); send_str("123"); send_key(8'h0D);
        do_start(); send_str("99999"); send_key(8'h0D);
        do_start(); send_str("65535"); send_key(8'h0D);
        do_start(); send_str("1234567"); send_key(8'h0D);
        do_start(); send_key(8'h61); send_key(8'h0D);

        do_start(); send_str("12");
        start = 1'b1; tick(); start = 1'b0;
        chk("start_while_busy_cnt", digit_cnt, 2);
        chk("start_while_busy_busy", busy, 1);
        send_key(8'h0D);

        do_start();
        ready_low = 1'b1;
        tick();
        tgt = xfer_cnt + 1;
        digits.push_back(7);
        echo_q.push_back(8'h37);
        pulse_raw(8'h37);
        repeat (50) tick();
        chk("stall_echo_valid", echo_valid, 1);
        chk("stall_echo_byte", echo_byte, 8'h37);
        pulse_raw(8'h38);
        chk("echo_drop_cnt", digit_cnt, 1);
        ready_low = 1'b0;
        wait_xfer(tgt);
        send_key(8'h0D);

        do_start(); send_str("42");
        #3 rst = 1'b1;
        #1 check_reset_outputs();
        echo_q.delete();
        digits.delete();
        tick(); tick();
        rst = 1'b0;
        tick();
        do_start(); send_str("5"); send_key(8'h0D);

`ifdef UART_DEC_READER_BACKSPACE_EN
        do_start(); send_key(8'h7F); send_str("12"); send_key(8'h08); send_str("3"); send_key(8'h0D);
`endif

        repeat (40) begin
            do_start();
            n = $urandom_range(0, 9);
            repeat (n) send_key(rand_key());
            send_key(8'h0D);
        end

        repeat (5) tick();
        chk("echo_queue_drained", echo_q.size(), 0);
        chk("num_queue_drained", num_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
